// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage with a valid/ready handshake, synchronous flush and an optional
// 2-entry skid buffer (SKID=1) that makes in_ready a pure register output.
module wb_pipe_stage #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32,
  parameter int ASIZE = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic             memtoreg_in,
  input  logic             wen_in,
  input  logic [ISIZE-1:0] pc_in,
  input  logic             jal_in,
  input  logic [ASIZE-1:0] waddr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] aluout_out,
  output logic             memtoreg_out,
  output logic             wen_out,
  output logic [ISIZE-1:0] pc_out,
  output logic             jal_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             fwd_valid,
  output logic [ASIZE-1:0] fwd_addr,
  output logic [DSIZE-1:0] fwd_data,
  output logic [1:0]       occupancy
);

  localparam int PW = DSIZE + ISIZE + ASIZE + 3;

  // S_ONE doubles as FULL when SKID=0; S_TWO is then unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   in_pl;
  logic            accept, pop;

  logic [DSIZE-1:0] h_alu;
  logic             h_m2r, h_wen, h_jal;
  logic [ISIZE-1:0] h_pc;
  logic [ASIZE-1:0] h_waddr;
  logic [DSIZE-1:0] pc_fit;

  assign in_pl = {aluout_in, memtoreg_in, wen_in, pc_in, jal_in, waddr_in};
  assign {h_alu, h_m2r, h_wen, h_pc, h_jal, h_waddr} = head_q;

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush && !rst;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          head_d  = in_pl;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          head_d = in_pl;
        end else if (accept) begin
          state_d = S_TWO;
          skid_d  = in_pl;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          state_d = S_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Payload registers carry no reset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign pc_fit       = DSIZE'(h_pc);
  assign aluout_out   = out_valid ? h_alu   : '0;
  assign memtoreg_out = out_valid && h_m2r;
  assign wen_out      = out_valid && h_wen;
  assign pc_out       = out_valid ? h_pc    : '0;
  assign jal_out      = out_valid && h_jal;
  assign waddr_out    = out_valid ? h_waddr : '0;
  assign fwd_valid    = out_valid && h_wen && !h_m2r && (h_waddr != '0);
  assign fwd_addr     = waddr_out;
  assign fwd_data     = out_valid ? (h_jal ? pc_fit : h_alu) : '0;
  assign occupancy    = {state_q == S_TWO, state_q == S_ONE};

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: a SKID=0 instance (narrow PC) and a SKID=1 instance (wide PC)
// share one input stream and are each compared against a queue-based reference model.
module tb_wb_pipe_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic        m2r;
    logic        wen;
    logic        jal;
    logic [63:0] pc;
    logic [4:0]  wa;
  } pl_t;

  localparam logic [63:0] M0 = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] M1 = 64'h0000_00FF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] aluout_in;
  logic        memtoreg_in, wen_in, jal_in;
  logic [63:0] pc_in;
  logic [4:0]  waddr_in;

  logic        ir0, ov0, m2r0, wen0, jal0, fv0;
  logic [31:0] alu0, fd0;
  logic [15:0] pc0;
  logic [4:0]  wa0, fa0;
  logic [1:0]  occ0;

  logic        ir1, ov1, m2r1, wen1, jal1, fv1;
  logic [31:0] alu1, fd1;
  logic [39:0] pc1;
  logic [4:0]  wa1, fa1;
  logic [1:0]  occ1;

  int vectors = 0;
  int miscompares = 0;
  pl_t q0[$];
  pl_t q1[$];

  always #5 clk = ~clk;

  wb_pipe_stage #(.DSIZE(32), .ISIZE(16), .ASIZE(5), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .aluout_in(aluout_in), .memtoreg_in(memtoreg_in), .wen_in(wen_in),
    .pc_in(pc_in[15:0]), .jal_in(jal_in), .waddr_in(waddr_in),
    .out_valid(ov0), .out_ready(out_ready), .aluout_out(alu0), .memtoreg_out(m2r0),
    .wen_out(wen0), .pc_out(pc0), .jal_out(jal0), .waddr_out(wa0),
    .fwd_valid(fv0), .fwd_addr(fa0), .fwd_data(fd0), .occupancy(occ0)
  );

  wb_pipe_stage #(.DSIZE(32), .ISIZE(40), .ASIZE(5), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .aluout_in(aluout_in), .memtoreg_in(memtoreg_in), .wen_in(wen_in),
    .pc_in(pc_in[39:0]), .jal_in(jal_in), .waddr_in(waddr_in),
    .out_valid(ov1), .out_ready(out_ready), .aluout_out(alu1), .memtoreg_out(m2r1),
    .wen_out(wen1), .pc_out(pc1), .jal_out(jal1), .waddr_out(wa1),
    .fwd_valid(fv1), .fwd_addr(fa1), .fwd_data(fd1), .occupancy(occ1)
  );

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t mk(input logic [63:0] mask);
    pl_t p;
    p.alu = aluout_in;
    p.m2r = memtoreg_in;
    p.wen = wen_in;
    p.jal = jal_in;
    p.pc  = pc_in & mask;
    p.wa  = waddr_in;
    return p;
  endfunction

  task automatic chk(input string nm, input bit exp_ir, input int sz, input pl_t hd,
                     input logic ir, input logic ov, input logic [31:0] alu, input logic m2r,
                     input logic wen, input logic [63:0] pc, input logic jal, input logic [4:0] wa,
                     input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                     input logic [1:0] occ);
    bit v;
    v = (sz > 0);
    cmp({nm, "_in_ready"}, ir, exp_ir);
    cmp({nm, "_out_valid"}, ov, v);
    cmp({nm, "_occupancy"}, occ, sz);
    cmp({nm, "_wen_out"}, wen, v && hd.wen);
    cmp({nm, "_jal_out"}, jal, v && hd.jal);
    cmp({nm, "_fwd_valid"}, fv, v && hd.wen && !hd.m2r && (hd.wa != 0));
    if (v) begin
      cmp({nm, "_aluout"}, alu, hd.alu);
      cmp({nm, "_memtoreg"}, m2r, hd.m2r);
      cmp({nm, "_pc"}, pc, hd.pc);
      cmp({nm, "_waddr"}, wa, hd.wa);
      cmp({nm, "_fwd_addr"}, fa, hd.wa);
      cmp({nm, "_fwd_data"}, fd, hd.jal ? hd.pc[31:0] : hd.alu);
    end
  endtask

  // One clock: check both DUTs against the models mid-cycle, then advance the models.
  task automatic cycle();
    bit  er0, er1, acc0, acc1, pop0, pop1;
    pl_t h0, h1, n0, n1;
    @(negedge clk);
    h0 = '0;
    h1 = '0;
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    er0 = (q0.size() == 0) || out_ready;
    er1 = (q1.size() < 2);
    chk("s0", er0, q0.size(), h0, ir0, ov0, alu0, m2r0, wen0, 64'(pc0), jal0, wa0, fv0, fa0, fd0, occ0);
    chk("s1", er1, q1.size(), h1, ir1, ov1, alu1, m2r1, wen1, 64'(pc1), jal1, wa1, fv1, fa1, fd1, occ1);
    acc0 = in_valid && er0 && !flush && !rst;
    acc1 = in_valid && er1 && !flush && !rst;
    pop0 = (q0.size() > 0) && out_ready;
    pop1 = (q1.size() > 0) && out_ready;
    n0 = mk(M0);
    n1 = mk(M1);
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (acc0) q0.push_back(n0);
        if (acc1) q1.push_back(n1);
      end
    end
    #1;
  endtask

  task automatic rand_payload();
    aluout_in   = $urandom;
    memtoreg_in = 1'($urandom_range(0, 1));
    wen_in      = 1'($urandom_range(0, 1));
    jal_in      = 1'($urandom_range(0, 1));
    pc_in       = {$urandom, $urandom};
    waddr_in    = 5'($urandom_range(0, 31));
  endtask

  initial begin
    logic [31:0] va, vb;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_payload();

    // Reset held two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Back-to-back stream of 8 entries.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      cycle();
      cmp("stream_occ1", occ1, 2'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Two pushes against a stalled consumer, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_payload(); va = aluout_in;
    cycle();
    rand_payload(); vb = aluout_in;
    cycle();
    in_valid = 1'b0;
    cmp("skid_occ_two", occ1, 2'd2);
    cmp("skid_ready_low", ir1, 1'b0);
    out_ready = 1'b1;
    cmp("skid_head_a", alu1, va);
    cycle();
    cmp("skid_head_b", alu1, vb);
    cycle();
    cmp("skid_drained", occ1, 2'd0);

    // Flush while full with a valid input in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      rand_payload();
      cycle();
    end
    flush = 1'b1;
    rand_payload();
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp("flush_valid1", ov1, 1'b0);
    cmp("flush_occ1", occ1, 2'd0);
    cmp("flush_valid0", ov0, 1'b0);
    cycle();

    // Forwarding of a link write, then with waddr=0.
    in_valid = 1'b1;
    aluout_in = 32'h1234; memtoreg_in = 1'b0; wen_in = 1'b1; jal_in = 1'b1;
    pc_in = 64'h40; waddr_in = 5'd31;
    cycle();
    in_valid = 1'b0;
    cmp("jal_fwd_valid", fv1, 1'b1);
    cmp("jal_fwd_addr", fa1, 5'd31);
    cmp("jal_fwd_data1", fd1, 32'h40);
    cmp("jal_fwd_data0", fd0, 32'h40);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b1;
    waddr_in = 5'd0;
    cycle();
    in_valid = 1'b0;
    cmp("zero_fwd_valid1", fv1, 1'b0);
    cmp("zero_fwd_valid0", fv0, 1'b0);
    cycle();

    // Reset in the middle of operation.
    in_valid = 1'b1;
    repeat (2) begin
      rand_payload();
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    cmp("midrst_occ1", occ1, 2'd0);
    cmp("midrst_occ0", occ0, 2'd0);
    cycle();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      rand_payload();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
